// File: rtl/wbs_gpio_irq.sv
// Wishbone slave combining GPIO, an edge/level interrupt controller with W1C status,
// and an auto-reload down-counter timer that feeds the top status bit.
module wbs_gpio_irq #(
  parameter int unsigned DW     = 16,
  parameter int unsigned AW     = 9,
  parameter int unsigned NGPIO  = 16,
  parameter int unsigned NIRQ   = 8,
  parameter logic [31:0] ID_VAL = 32'h3060
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [AW-1:0]     wb_adr_i,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic [DW/8-1:0]   wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic [DW-1:0]     wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_rty_o,
  input  logic [NGPIO-1:0]  gpio_i,
  output logic [NGPIO-1:0]  gpio_o,
  input  logic [NIRQ-1:0]   irq_src_i,
  output logic              int_o
);
  localparam int unsigned NB  = DW / 8;
  localparam int unsigned LSB = $clog2(NB);
  localparam int unsigned IW  = AW - LSB;
  localparam int unsigned SW  = NIRQ + 1;

  localparam logic [IW-1:0] IDX_ID       = IW'(0);
  localparam logic [IW-1:0] IDX_GPIO_OUT = IW'(1);
  localparam logic [IW-1:0] IDX_GPIO_IN  = IW'(2);
  localparam logic [IW-1:0] IDX_STATUS   = IW'(3);
  localparam logic [IW-1:0] IDX_MASK     = IW'(4);
  localparam logic [IW-1:0] IDX_EDGE     = IW'(5);
  localparam logic [IW-1:0] IDX_CTRL     = IW'(6);
  localparam logic [IW-1:0] IDX_SET      = IW'(7);
  localparam logic [IW-1:0] IDX_TMR_CTRL = IW'(8);
  localparam logic [IW-1:0] IDX_TMR_LOAD = IW'(9);
  localparam logic [IW-1:0] IDX_TMR_CNT  = IW'(10);

  logic              acc, wr;
  logic [IW-1:0]     idx;
  logic [DW-1:0]     bm, wd, rdata;
  logic [NGPIO-1:0]  gpio_s1, gpio_s2, gpio_out_n;
  logic [NIRQ-1:0]   irq_s1, irq_s2, irq_d, hit;
  logic [NIRQ-1:0]   edge_cfg, edge_cfg_n;
  logic [SW-1:0]     status, status_n, mask, mask_n, clr, set_sw;
  logic              int_en, int_en_n;
  logic              run, run_n, auto_rl, auto_rl_n, expire, ctl_wr;
  logic [DW-1:0]     load, load_n, cnt, cnt_n;
  logic              unused_adr;

  assign acc        = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr         = acc & wb_we_i;
  assign idx        = wb_adr_i[AW-1:LSB];
  assign wd         = wb_dat_i & bm;
  assign wb_err_o   = 1'b0;
  assign wb_rty_o   = 1'b0;
  assign unused_adr = ^wb_adr_i[LSB-1:0];

  // Expand byte selects into a bit mask.
  always_comb begin
    bm = '0;
    for (int unsigned i = 0; i < NB; i++) bm[8*i +: 8] = {8{wb_sel_i[i]}};
  end

  // Edge sources fire on a synchronised rising edge, level sources every cycle high.
  assign hit = irq_s2 & (~irq_d | ~edge_cfg);

  // Register writes, timer sequencing and status update.
  always_comb begin
    gpio_out_n = gpio_o;
    mask_n     = mask;
    edge_cfg_n = edge_cfg;
    int_en_n   = int_en;
    load_n     = load;
    clr        = '0;
    set_sw     = '0;
    ctl_wr     = 1'b0;
    run_n      = run;
    auto_rl_n  = auto_rl;
    cnt_n      = cnt;
    expire     = run & (cnt == '0);

    if (wr) begin
      case (idx)
        IDX_GPIO_OUT: gpio_out_n = (gpio_o & ~bm[NGPIO-1:0]) | wd[NGPIO-1:0];
        IDX_STATUS:   clr        = wd[SW-1:0];
        IDX_MASK:     mask_n     = (mask & ~bm[SW-1:0]) | wd[SW-1:0];
        IDX_EDGE:     edge_cfg_n = (edge_cfg & ~bm[NIRQ-1:0]) | wd[NIRQ-1:0];
        IDX_CTRL:     if (wb_sel_i[0]) int_en_n = wb_dat_i[0];
        IDX_SET:      set_sw     = wd[SW-1:0];
        IDX_TMR_CTRL: ctl_wr     = wb_sel_i[0];
        IDX_TMR_LOAD: load_n     = (load & ~bm) | wd;
        default: ;
      endcase
    end

    if (run) begin
      if (!expire)      cnt_n = cnt - DW'(1);
      else if (auto_rl) cnt_n = load;
      else              run_n = 1'b0;
    end

    // A bus write to the timer control overrides the expiry outcome for run.
    if (ctl_wr) begin
      run_n     = wb_dat_i[0];
      auto_rl_n = wb_dat_i[1];
      if (wb_dat_i[0]) cnt_n = load;
    end

    status_n = (status & ~clr) | set_sw | {expire, hit};
  end

  always_comb begin
    rdata = '0;
    case (idx)
      IDX_ID:       rdata = ID_VAL[DW-1:0];
      IDX_GPIO_OUT: rdata = DW'(gpio_o);
      IDX_GPIO_IN:  rdata = DW'(gpio_s2);
      IDX_STATUS:   rdata = DW'(status);
      IDX_MASK:     rdata = DW'(mask);
      IDX_EDGE:     rdata = DW'(edge_cfg);
      IDX_CTRL:     rdata = DW'(int_en);
      IDX_TMR_CTRL: rdata = DW'({auto_rl, run});
      IDX_TMR_LOAD: rdata = load;
      IDX_TMR_CNT:  rdata = cnt;
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      gpio_o   <= '0;
      gpio_s1  <= '0;
      gpio_s2  <= '0;
      irq_s1   <= '0;
      irq_s2   <= '0;
      irq_d    <= '0;
      status   <= '0;
      mask     <= '0;
      edge_cfg <= '0;
      int_en   <= 1'b0;
      run      <= 1'b0;
      auto_rl  <= 1'b0;
      load     <= '0;
      cnt      <= '0;
      int_o    <= 1'b0;
    end else begin
      wb_ack_o <= acc;
      if (acc && !wb_we_i) wb_dat_o <= rdata;
      gpio_o   <= gpio_out_n;
      gpio_s1  <= gpio_i;
      gpio_s2  <= gpio_s1;
      irq_s1   <= irq_src_i;
      irq_s2   <= irq_s1;
      irq_d    <= irq_s2;
      status   <= status_n;
      mask     <= mask_n;
      edge_cfg <= edge_cfg_n;
      int_en   <= int_en_n;
      run      <= run_n;
      auto_rl  <= auto_rl_n;
      load     <= load_n;
      cnt      <= cnt_n;
      int_o    <= int_en & (|(status & mask));
    end
  end
endmodule

// File: tb/tb_wbs_gpio_irq.sv
// Testbench for wbs_gpio_irq (DW=16): vector table, randomized register traffic against
// a register-level model, and directed interrupt/timer/reset sequences.
module tb_wbs_gpio_irq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  adr = '0;
  logic [15:0] dat_i = '0;
  logic [1:0]  sel = '0;
  logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic [15:0] dat_o;
  logic        ack, err, rty;
  logic [15:0] gpio_i = '0;
  logic [15:0] gpio_o;
  logic [7:0]  irq_src = '0;
  logic        int_o;

  wbs_gpio_irq dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .wb_err_o(err), .wb_rty_o(rty), .gpio_i(gpio_i), .gpio_o(gpio_o),
    .irq_src_i(irq_src), .int_o(int_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc_cnt = 0;
  int unsigned last_edge = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Register-level model of the software-visible state.
  logic [15:0] m_gpo = '0, m_gpi = '0, m_status = '0, m_mask = '0, m_edge = '0, m_load = '0;
  logic        m_inten = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] s);
    logic [15:0] r;
    r = old;
    for (int b = 0; b < 2; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic model_wr(input int unsigned i, input logic [15:0] d, input logic [1:0] s);
    case (i)
      1: m_gpo    = merge(m_gpo, d, s);
      3: m_status = m_status & ~merge(16'h0, d, s);
      4: m_mask   = merge(m_mask, d, s) & 16'h01FF;
      5: m_edge   = merge(m_edge, d, s) & 16'h00FF;
      6: if (s[0]) m_inten = d[0];
      7: m_status = (m_status | merge(16'h0, d, s)) & 16'h01FF;
      9: m_load   = merge(m_load, d, s);
      default: ;
    endcase
  endtask

  function automatic logic [15:0] model_rd(input int unsigned i);
    case (i)
      0:       return 16'h3060;
      1:       return m_gpo;
      2:       return m_gpi;
      3:       return m_status;
      4:       return m_mask;
      5:       return m_edge;
      6:       return {15'h0, m_inten};
      9:       return m_load;
      default: return 16'h0;
    endcase
  endfunction

  task automatic bus(input logic w, input logic [8:0] a, input logic [15:0] d,
                     input logic [1:0] s, output logic [15:0] r);
    @(negedge clk);
    adr = a; dat_i = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    last_edge = cyc_cnt;
    chk("ack", 32'(ack), 32'd1);
    r = dat_o;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [8:0] a, input logic [15:0] d, input logic [1:0] s);
    logic [15:0] r;
    bus(1'b1, a, d, s, r);
    model_wr(32'(a[8:1]), d, s);
  endtask

  task automatic rd(input string nm, input logic [8:0] a, input logic [15:0] e);
    logic [15:0] r;
    bus(1'b0, a, 16'h0, 2'b11, r);
    chk(nm, 32'(r), 32'(e));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // True if a timer expiry (every LOAD+1 edges after the start edge) falls in [lo, hi].
  function automatic bit expiry_in(input int unsigned lo, input int unsigned hi,
                                   input int unsigned per);
    for (int unsigned j = lo; j <= hi; j++) if (j >= per && (j % per) == 0) return 1'b1;
    return 1'b0;
  endfunction

  typedef struct {
    logic        w;
    logic [8:0]  a;
    logic [15:0] d;
    logic [1:0]  s;
    logic [15:0] exp;
    logic [15:0] gpo;
  } vec_t;
  vec_t tbl[29];

  initial begin
    logic [15:0] r;
    int unsigned e0, c, d, ex;
    int unsigned widx[7] = '{1, 3, 4, 5, 6, 7, 9};

    tbl[0]  = '{1'b0, 9'd0,   16'h0000, 2'b11, 16'h3060, 16'h0000};
    tbl[1]  = '{1'b1, 9'd2,   16'hA5C3, 2'b01, 16'h0000, 16'h00C3};
    tbl[2]  = '{1'b0, 9'd2,   16'h0000, 2'b11, 16'h00C3, 16'h00C3};
    tbl[3]  = '{1'b1, 9'd3,   16'hA5C3, 2'b10, 16'h0000, 16'hA5C3};
    tbl[4]  = '{1'b0, 9'd2,   16'h0000, 2'b11, 16'hA5C3, 16'hA5C3};
    tbl[5]  = '{1'b1, 9'd0,   16'hFFFF, 2'b11, 16'h0000, 16'hA5C3};
    tbl[6]  = '{1'b0, 9'd1,   16'h0000, 2'b11, 16'h3060, 16'hA5C3};
    tbl[7]  = '{1'b1, 9'd8,   16'hFFFF, 2'b11, 16'h0000, 16'hA5C3};
    tbl[8]  = '{1'b0, 9'd8,   16'h0000, 2'b11, 16'h01FF, 16'hA5C3};
    tbl[9]  = '{1'b1, 9'd10,  16'hFFFF, 2'b11, 16'h0000, 16'hA5C3};
    tbl[10] = '{1'b0, 9'd10,  16'h0000, 2'b11, 16'h00FF, 16'hA5C3};
    tbl[11] = '{1'b1, 9'd12,  16'hFFFF, 2'b10, 16'h0000, 16'hA5C3};
    tbl[12] = '{1'b0, 9'd12,  16'h0000, 2'b11, 16'h0000, 16'hA5C3};
    tbl[13] = '{1'b1, 9'd14,  16'h0001, 2'b01, 16'h0000, 16'hA5C3};
    tbl[14] = '{1'b0, 9'd14,  16'h0000, 2'b11, 16'h0000, 16'hA5C3};
    tbl[15] = '{1'b0, 9'd6,   16'h0000, 2'b11, 16'h0001, 16'hA5C3};
    tbl[16] = '{1'b1, 9'd6,   16'h0100, 2'b11, 16'h0000, 16'hA5C3};
    tbl[17] = '{1'b0, 9'd6,   16'h0000, 2'b11, 16'h0001, 16'hA5C3};
    tbl[18] = '{1'b1, 9'd6,   16'h0001, 2'b10, 16'h0000, 16'hA5C3};
    tbl[19] = '{1'b0, 9'd6,   16'h0000, 2'b11, 16'h0001, 16'hA5C3};
    tbl[20] = '{1'b1, 9'd6,   16'h0001, 2'b01, 16'h0000, 16'hA5C3};
    tbl[21] = '{1'b0, 9'd6,   16'h0000, 2'b11, 16'h0000, 16'hA5C3};
    tbl[22] = '{1'b1, 9'd18,  16'h1234, 2'b11, 16'h0000, 16'hA5C3};
    tbl[23] = '{1'b0, 9'd18,  16'h0000, 2'b11, 16'h1234, 16'hA5C3};
    tbl[24] = '{1'b0, 9'd20,  16'h0000, 2'b11, 16'h0000, 16'hA5C3};
    tbl[25] = '{1'b1, 9'd22,  16'hFFFF, 2'b11, 16'h0000, 16'hA5C3};
    tbl[26] = '{1'b0, 9'd22,  16'h0000, 2'b11, 16'h0000, 16'hA5C3};
    tbl[27] = '{1'b0, 9'd200, 16'h0000, 2'b11, 16'h0000, 16'hA5C3};
    tbl[28] = '{1'b0, 9'd16,  16'h0000, 2'b11, 16'h0000, 16'hA5C3};

    // Reset state
    #12;
    chk("rst_dat", 32'(dat_o), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_gpio", 32'(gpio_o), 32'h0);
    chk("rst_int", 32'(int_o), 32'h0);
    chk("rst_err_rty", 32'({err, rty}), 32'h0);
    @(negedge clk); rst = 1'b0;
    idle(2);

    // ID read with strobe held: ack for exactly one cycle
    @(negedge clk);
    adr = 9'd0; we = 1'b0; sel = 2'b11; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    chk("t1_ack_hi", 32'(ack), 32'd1);
    chk("t1_id", 32'(dat_o), 32'h3060);
    @(posedge clk); #1;
    chk("t1_ack_lo", 32'(ack), 32'd0);
    @(negedge clk); cyc = 1'b0; stb = 1'b0;

    foreach (tbl[i]) begin
      if (tbl[i].w) wr(tbl[i].a, tbl[i].d, tbl[i].s);
      else          rd($sformatf("tbl%0d", i), tbl[i].a, tbl[i].exp);
      chk($sformatf("tbl%0d_gpio", i), 32'(gpio_o), 32'(tbl[i].gpo));
    end

    // GPIO input through the synchroniser
    gpio_i = 16'h1234; m_gpi = 16'h1234;
    idle(2);
    rd("t2_gpio_in", 9'd4, 16'h1234);

    // Randomized register traffic against the model
    for (int k = 0; k < 150; k++) begin
      int unsigned op, i;
      logic [8:0] a;
      op = $urandom_range(0, 2);
      if (op == 0) begin
        i = widx[$urandom_range(0, 6)];
        a = {8'(i), 1'($urandom_range(0, 1))};
        wr(a, 16'($urandom), 2'($urandom_range(0, 3)));
      end else begin
        if (op == 2) begin
          gpio_i = 16'($urandom); m_gpi = gpio_i;
          idle(2);
          i = 2;
        end else begin
          i = $urandom_range(0, 15);
        end
        a = {8'(i), 1'($urandom_range(0, 1))};
        rd($sformatf("rnd%0d_idx%0d", k, i), a, model_rd(i));
      end
      idle(1);
      chk($sformatf("rnd%0d_gpio", k), 32'(gpio_o), 32'(m_gpo));
      chk($sformatf("rnd%0d_int", k), 32'(int_o),
          32'(m_inten & (|(m_status & m_mask))));
    end

    // Edge source: held high sets status once; W1C does not re-set it
    wr(9'd6, 16'h01FF, 2'b11);
    wr(9'd8, 16'h0003, 2'b11);
    wr(9'd10, 16'h0001, 2'b11);
    wr(9'd12, 16'h0001, 2'b11);
    @(negedge clk); irq_src[0] = 1'b1;
    idle(4);
    rd("t3_status", 9'd6, 16'h0001);
    chk("t3_int_hi", 32'(int_o), 32'd1);
    wr(9'd6, 16'h0001, 2'b11);
    idle(4);
    chk("t3_int_lo", 32'(int_o), 32'd0);
    rd("t3_status_clr", 9'd6, 16'h0000);
    irq_src[0] = 1'b0;

    // Level source: W1C on a held level re-sets immediately
    irq_src[1] = 1'b1;
    idle(4);
    rd("t4_status", 9'd6, 16'h0002);
    wr(9'd6, 16'h0002, 2'b11);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t4_int_hold%0d", k), 32'(int_o), 32'd1);
      @(negedge clk);
    end
    rd("t4_status_reset", 9'd6, 16'h0002);
    irq_src[1] = 1'b0;
    idle(4);
    wr(9'd6, 16'h0002, 2'b11);
    idle(2);
    chk("t4_int_lo", 32'(int_o), 32'd0);
    rd("t4_status_clr", 9'd6, 16'h0000);

    // cyc dropped before the edge: no ack and no write
    @(negedge clk);
    adr = 9'd2; dat_i = ~m_gpo; sel = 2'b11; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    #2 cyc = 1'b0;
    @(posedge clk); #1;
    chk("drop_ack", 32'(ack), 32'd0);
    @(negedge clk); stb = 1'b0; we = 1'b0;
    chk("drop_gpio", 32'(gpio_o), 32'(m_gpo));

    // Auto-reload timer, LOAD=3: period 4 cycles
    wr(9'd6, 16'h01FF, 2'b11);
    wr(9'd18, 16'h0003, 2'b11);
    wr(9'd16, 16'h0003, 2'b11);
    e0 = last_edge;
    for (int k = 0; k < 6; k++) begin
      idle($urandom_range(0, 1));
      bus(1'b0, 9'd20, 16'h0, 2'b11, r);
      ex = 3 - ((last_edge - 1 - e0) % 4);
      chk($sformatf("t5_cnt%0d", k), 32'(r), ex);
    end
    for (int k = 0; k < 6; k++) begin
      wr(9'd6, 16'h0100, 2'b11);
      c = last_edge;
      idle($urandom_range(0, 4));
      bus(1'b0, 9'd6, 16'h0, 2'b11, r);
      d = last_edge;
      chk($sformatf("t5_period%0d", k), 32'(r),
          expiry_in(c - e0, d - 1 - e0, 4) ? 32'h0100 : 32'h0);
    end

    // One-shot: single expiry, run clears itself, count holds
    wr(9'd16, 16'h0001, 2'b11);
    wr(9'd6, 16'h0100, 2'b11);
    rd("t5_os_running", 9'd16, 16'h0001);
    idle(2);
    rd("t5_os_status", 9'd6, 16'h0100);
    rd("t5_os_stopped", 9'd16, 16'h0000);
    rd("t5_os_cnt", 9'd20, 16'h0000);
    wr(9'd6, 16'h0100, 2'b11);
    idle(10);
    rd("t5_os_once", 9'd6, 16'h0000);

    // Asynchronous reset while counting, with int_o and ack high
    wr(9'd2, 16'hFFFF, 2'b11);
    wr(9'd8, 16'h0100, 2'b11);
    wr(9'd12, 16'h0001, 2'b11);
    wr(9'd16, 16'h0003, 2'b11);
    idle(8);
    chk("t6_int_pre", 32'(int_o), 32'd1);
    @(negedge clk);
    adr = 9'd0; we = 1'b0; sel = 2'b11; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    chk("t6_ack_pre", 32'(ack), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_ack", 32'(ack), 32'd0);
    chk("t6_dat", 32'(dat_o), 32'd0);
    chk("t6_gpio", 32'(gpio_o), 32'd0);
    chk("t6_int", 32'(int_o), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk); rst = 1'b0;
    rd("t6_cnt", 9'd20, 16'h0000);
    rd("t6_tctl", 9'd16, 16'h0000);
    rd("t6_mask", 9'd8, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
